// File: rtl/cache_line_mover.sv
// Cache block mover: optional dirty-victim writeback SRAM->memory, then refill memory->SRAM with critical-word forwarding.
// Define CACHE_LINE_MOVER_CRITICAL_WORD_FIRST_EN to start the refill at fill_word instead of word 0.
module cache_line_mover #(
    parameter int LANES       = 4,
    parameter int BLOCK_WORDS = 32,
    parameter int SRAM_AW     = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req,
    input  logic                           evict,
    input  logic [31:0]                    victim_addr,
    input  logic [31:0]                    fill_addr,
    input  logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    input  logic [SRAM_AW-1:0]             sram_base,
    output logic                           busy,
    output logic                           done,
    output logic                           crit_valid,
    output logic [8*LANES-1:0]             crit_data,
    output logic                           mem_ren,
    output logic                           mem_wen,
    output logic [31:0]                    mem_addr,
    output logic [8*LANES-1:0]             mem_din,
    input  logic [8*LANES-1:0]             mem_dout,
    input  logic                           mem_busy,
    output logic [8*LANES-1:0]             cell_din,
    output logic [LANES-1:0]               cell_sense_en,
    output logic [LANES-1:0]               cell_wen,
    output logic [SRAM_AW-1:0]             cell_addr,
    input  logic [8*LANES-1:0]             cell_dout
);

    localparam int DW = 8 * LANES;
    localparam int WW = $clog2(BLOCK_WORDS);

`ifdef CACHE_LINE_MOVER_CRITICAL_WORD_FIRST_EN
    localparam bit CWF_EN = 1'b1;
`else
    localparam bit CWF_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [31:0] word_off(input logic [WW-1:0] idx);
        word_off = 32'(idx) * 32'(LANES);
    endfunction

    function automatic logic [SRAM_AW-1:0] sram_at(input logic [SRAM_AW-1:0] base,
                                                   input logic [WW-1:0] idx);
        sram_at = base + SRAM_AW'(idx);
    endfunction

    function automatic logic [WW-1:0] fill_start(input logic [WW-1:0] fw);
        fill_start = CWF_EN ? fw : {WW{1'b0}};
    endfunction

    state_t              state_r;
    logic [31:0]         victim_r;
    logic [31:0]         fill_r;
    logic [WW-1:0]       fw_r;
    logic [SRAM_AW-1:0]  base_r;
    logic [WW-1:0]       rd_idx_r;
    logic                rd_en_r;
    logic                wen_r;
    logic                hold_valid_r;
    logic [DW-1:0]       hold_data_r;
    logic [WW-1:0]       fc_r;
    logic                ren_r;
    logic [31:0]         addr_r;
    logic                cwen_r;
    logic [SRAM_AW-1:0]  caddr_r;
    logic                crit_r;
    logic                busy_r;
    logic                done_r;

    logic                sense_fire_s;
    logic                wr_accept_s;
    logic                rd_accept_s;
    logic [WW-1:0]       fill_w_s;

    // SRAM reads are gated by the stall combinationally so a held write never has a second word racing behind it.
    assign sense_fire_s = (state_r == WB) & rd_en_r & ~mem_busy;
    assign wr_accept_s  = wen_r & ~mem_busy;
    assign rd_accept_s  = ren_r & ~mem_busy;
    assign fill_w_s     = fill_start(fw_r) + fc_r;

    assign busy          = busy_r;
    assign done          = done_r;
    assign crit_valid    = crit_r;
    assign crit_data     = crit_r ? mem_dout : {DW{1'b0}};
    assign mem_ren       = ren_r;
    assign mem_wen       = wen_r;
    assign mem_addr      = addr_r;
    assign mem_din       = !wen_r ? {DW{1'b0}} : (hold_valid_r ? hold_data_r : cell_dout);
    assign cell_din      = cwen_r ? mem_dout : {DW{1'b0}};
    assign cell_sense_en = {LANES{sense_fire_s}};
    assign cell_wen      = {LANES{cwen_r}};
    assign cell_addr     = caddr_r;

    // Move sequencer: state, word counters and all registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            victim_r     <= 32'h0000_0000;
            fill_r       <= 32'h0000_0000;
            fw_r         <= {WW{1'b0}};
            base_r       <= {SRAM_AW{1'b0}};
            rd_idx_r     <= {WW{1'b0}};
            rd_en_r      <= 1'b0;
            wen_r        <= 1'b0;
            hold_valid_r <= 1'b0;
            hold_data_r  <= {DW{1'b0}};
            fc_r         <= {WW{1'b0}};
            ren_r        <= 1'b0;
            addr_r       <= 32'h0000_0000;
            cwen_r       <= 1'b0;
            caddr_r      <= {SRAM_AW{1'b0}};
            crit_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            crit_r <= 1'b0;
            cwen_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req) begin
                        victim_r <= victim_addr;
                        fill_r   <= fill_addr;
                        fw_r     <= fill_word;
                        base_r   <= sram_base;
                        busy_r   <= 1'b1;
                        if (evict) begin
                            state_r  <= WB;
                            rd_idx_r <= {WW{1'b0}};
                            rd_en_r  <= 1'b1;
                            caddr_r  <= sram_base;
                        end else begin
                            state_r <= FILL;
                            fc_r    <= {WW{1'b0}};
                            ren_r   <= 1'b1;
                            addr_r  <= fill_addr + word_off(fill_start(fill_word));
                        end
                    end
                end
                WB: begin
                    if (sense_fire_s) begin
                        wen_r        <= 1'b1;
                        hold_valid_r <= 1'b0;
                        addr_r       <= victim_r + word_off(rd_idx_r);
                        rd_idx_r     <= rd_idx_r + WW'(1);
                        caddr_r      <= sram_at(base_r, rd_idx_r + WW'(1));
                        rd_en_r      <= (rd_idx_r != WW'(BLOCK_WORDS - 1));
                    end else if (wr_accept_s) begin
                        // Last word accepted with nothing left to read: start the refill next cycle.
                        wen_r        <= 1'b0;
                        hold_valid_r <= 1'b0;
                        state_r      <= FILL;
                        fc_r         <= {WW{1'b0}};
                        ren_r        <= 1'b1;
                        addr_r       <= fill_r + word_off(fill_start(fw_r));
                    end else if (wen_r && !hold_valid_r) begin
                        hold_data_r  <= cell_dout;
                        hold_valid_r <= 1'b1;
                    end
                end
                FILL: begin
                    if (rd_accept_s) begin
                        cwen_r  <= 1'b1;
                        caddr_r <= sram_at(base_r, fill_w_s);
                        crit_r  <= (fill_w_s == fw_r);
                        fc_r    <= fc_r + WW'(1);
                        if (fc_r == WW'(BLOCK_WORDS - 1)) begin
                            ren_r <= 1'b0;
                        end else begin
                            addr_r <= fill_r + word_off(fill_w_s + WW'(1));
                        end
                    end else if (cwen_r && !ren_r) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_mover.sv
// Directed self-checking bench for cache_line_mover with behavioural SRAM and main-memory models.
module tb_cache_line_mover;

    localparam int LANES = 4;
    localparam int BW    = 32;
    localparam int AW    = 10;

`ifdef CACHE_LINE_MOVER_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        evict;
    logic [31:0] victim_addr;
    logic [31:0] fill_addr;
    logic [4:0]  fill_word;
    logic [9:0]  sram_base;
    logic        busy;
    logic        done;
    logic        crit_valid;
    logic [31:0] crit_data;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_busy;
    logic [31:0] cell_din;
    logic [3:0]  cell_sense_en;
    logic [3:0]  cell_wen;
    logic [9:0]  cell_addr;
    logic [31:0] cell_dout;

    cache_line_mover #(.LANES(LANES), .BLOCK_WORDS(BW), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .evict(evict),
        .victim_addr(victim_addr), .fill_addr(fill_addr), .fill_word(fill_word),
        .sram_base(sram_base), .busy(busy), .done(done), .crit_valid(crit_valid),
        .crit_data(crit_data), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy), .cell_din(cell_din),
        .cell_sense_en(cell_sense_en), .cell_wen(cell_wen), .cell_addr(cell_addr),
        .cell_dout(cell_dout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Models: SRAM and memory read latency of one cycle; unread cycles return junk.
    logic [31:0] sram   [0:1023];
    logic [31:0] wb_got [0:31];
    int          wb_cnt [0:31];
    int          wb_bad, done_cnt, crit_cnt, crit_pos, sram_wr_cnt, rd_cnt;
    logic [31:0] crit_dat, rd_addr0, rd_addr1, victim_cur;
    bit          clr_go = 1'b0;
    bit          preload_go = 1'b0;
    wire  [31:0] woff = mem_addr - victim_cur;

    always @(posedge clk) begin
        cell_dout <= (cell_sense_en != 4'b0000) ? sram[cell_addr] : 32'hDEAD_BEEF;
        mem_dout  <= (mem_ren && !mem_busy) ? mem_addr : 32'hBAAD_F00D;
        if (cell_wen != 4'b0000) begin
            sram[cell_addr] <= cell_din;
            sram_wr_cnt     <= sram_wr_cnt + 1;
            if (crit_valid) crit_pos <= sram_wr_cnt + 1;
        end
        if (crit_valid) begin
            crit_cnt <= crit_cnt + 1;
            crit_dat <= crit_data;
        end
        if (mem_wen && !mem_busy) begin
            if (woff < 32'd128) begin
                wb_got[woff[6:2]] <= mem_din;
                wb_cnt[woff[6:2]] <= wb_cnt[woff[6:2]] + 1;
            end else begin
                wb_bad <= wb_bad + 1;
            end
        end
        if (mem_ren && !mem_busy) begin
            if (rd_cnt == 0) rd_addr0 <= mem_addr;
            if (rd_cnt == 1) rd_addr1 <= mem_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (clr_go) begin
            for (int i = 0; i < 32; i++) begin
                wb_got[i] <= 32'h0000_0000;
                wb_cnt[i] <= 0;
            end
            wb_bad <= 0; done_cnt <= 0; crit_cnt <= 0; crit_pos <= 0;
            sram_wr_cnt <= 0; rd_cnt <= 0;
            crit_dat <= 32'h0000_0000; rd_addr0 <= 32'h0000_0000; rd_addr1 <= 32'h0000_0000;
        end
        if (preload_go) begin
            for (int i = 0; i < 1024; i++) sram[i] <= {4{i[7:0]}};
        end
    end

    function automatic logic [31:0] exp_wb(input int base, input int i);
        int a;
        a = (base + i) % 1024;
        return {4{a[7:0]}};
    endfunction

    function automatic int fstart(input int fw);
        return CWF ? fw : 0;
    endfunction

    task automatic do_clr(input bit pre);
        @(negedge clk);
        clr_go = 1'b1;
        preload_go = pre;
        @(negedge clk);
        clr_go = 1'b0;
        preload_go = 1'b0;
    endtask

    task automatic run_move(input bit ev, input logic [31:0] va, input logic [31:0] fa,
                            input int fw, input int base, input int ws, input int fs,
                            input int rst_at, input int req2_at, output int lat);
        int fcyc, w;
        victim_cur = va;
        @(negedge clk);
        req = 1'b1; evict = ev; victim_addr = va; fill_addr = fa;
        fill_word = 5'(fw); sram_base = 10'(base);
        @(posedge clk);
        #1;
        req = 1'b0; evict = 1'b1; victim_addr = 32'h5555_5500;
        fill_addr = 32'h3333_3300; fill_word = 5'd17; sram_base = 10'd512;
        lat = -1;
        fcyc = ev ? (34 + ((ws > 0) ? 5 : 0)) : 1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            mem_busy = (ws > 0 && c >= ws && c < ws + 5) || (fs > 0 && c >= fs && c < fs + 5);
            req = (c == req2_at);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check_eq("rst_ctl", {busy, done, crit_valid, mem_ren, mem_wen, cell_sense_en, cell_wen},
                         128'd0);
                check_eq("rst_data", {crit_data, mem_addr, mem_din, cell_din}, 128'd0);
                check_eq("rst_caddr", {118'd0, cell_addr}, 128'd0);
                @(negedge clk);
                rst = 1'b0;
                mem_busy = 1'b0;
                lat = 0;
                break;
            end
            if (ws > 0 && c >= ws && c <= ws + 5)
                check_eq("wb_stall_hold", {mem_wen, mem_ren, mem_addr, mem_din},
                         {1'b1, 1'b0, va + 32'(4 * (ws - 2)), exp_wb(base, ws - 2)});
            if (fs > 0 && c >= fs && c <= fs + 5) begin
                w = (fstart(fw) + fs - fcyc) % 32;
                check_eq("fill_stall_hold", {mem_wen, mem_ren, mem_addr},
                         {1'b0, 1'b1, fa + 32'(4 * w)});
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        mem_busy = 1'b0;
        req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_fill(input string tag, input logic [31:0] fa, input int base);
        int good = 0;
        for (int i = 0; i < 32; i++)
            if (sram[(base + i) % 1024] === fa + 32'(4 * i)) good++;
        check_eq(tag, 128'(good), 128'd32);
    endtask

    task automatic check_wb(input string tag, input int base);
        int good = 0;
        for (int i = 0; i < 32; i++)
            if (wb_got[i] === exp_wb(base, i) && wb_cnt[i] == 1) good++;
        check_eq(tag, 128'(good), 128'd32);
        check_eq({tag, "_stray"}, 128'(wb_bad), 128'd0);
    endtask

    int lat;

    initial begin
        rst = 1'b1; req = 1'b0; evict = 1'b0; mem_busy = 1'b0;
        victim_addr = 32'h0; fill_addr = 32'h0; fill_word = 5'd0; sram_base = 10'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_ctl", {busy, done, crit_valid, mem_ren, mem_wen, cell_sense_en, cell_wen},
                 128'd0);
        check_eq("reset_data", {crit_data, mem_addr, mem_din, cell_din}, 128'd0);
        rst = 1'b0;
        do_clr(1'b1);
        check_eq("idle_busy", {126'd0, busy, done}, 128'd0);

        // Fill only
        run_move(1'b0, 32'h0, 32'hACE1_2000, 0, 0, 0, 0, 0, 0, lat);
        check_eq("fill_latency", 128'(lat), 128'd34);
        check_fill("fill_sram", 32'hACE1_2000, 0);
        check_eq("fill_wr_cnt", 128'(sram_wr_cnt), 128'd32);
        check_eq("fill_done_cnt", 128'(done_cnt), 128'd1);
        check_eq("fill_crit", {32'(crit_cnt), 32'(crit_pos), crit_dat}, {32'd1, 32'd1, 32'hACE1_2000});
        check_eq("fill_first_rd", {rd_addr0, rd_addr1}, {32'hACE1_2000, 32'hACE1_2004});
        check_eq("fill_idle", {126'd0, busy, mem_wen}, 128'd0);

        // Evict plus fill, critical word 31
        do_clr(1'b1);
        run_move(1'b1, 32'hBEEF_2000, 32'h0001_2380, 31, 0, 0, 0, 0, 0, lat);
        check_eq("ev_latency", 128'(lat), 128'd67);
        check_wb("ev_wb", 0);
        check_fill("ev_sram", 32'h0001_2380, 0);
        check_eq("ev_crit_data", {32'(crit_cnt), crit_dat}, {32'd1, 32'h0001_23FC});
        check_eq("ev_crit_pos", 128'(crit_pos), CWF ? 128'd1 : 128'd32);
        check_eq("ev_rd_order", {rd_addr0, rd_addr1},
                 CWF ? {32'h0001_23FC, 32'h0001_2380} : {32'h0001_2380, 32'h0001_2384});

        // Stalls mid-WB and mid-FILL, SRAM base wrapping past the top
        do_clr(1'b1);
        run_move(1'b1, 32'hC0DE_0000, 32'hFFFF_FF80, 5, 1010, 10, 50, 0, 0, lat);
        check_eq("stall_latency", 128'(lat), 128'd77);
        check_wb("stall_wb", 1010);
        check_fill("stall_sram", 32'hFFFF_FF80, 1010);
        check_eq("stall_crit", {32'(crit_cnt), crit_dat}, {32'd1, 32'hFFFF_FF94});
        check_eq("stall_cnts", {32'(sram_wr_cnt), 32'(rd_cnt)}, {32'd32, 32'd32});

        // Reset mid-FILL, then a fresh move
        do_clr(1'b0);
        run_move(1'b0, 32'h0, 32'h0000_4000, 3, 100, 0, 0, 10, 0, lat);
        repeat (5) @(negedge clk);
        check_eq("rst_no_done", {32'(done_cnt), 31'd0, busy}, 128'd0);
        do_clr(1'b0);
        run_move(1'b0, 32'h0, 32'h0000_5000, 0, 200, 0, 0, 0, 0, lat);
        check_eq("post_rst_latency", 128'(lat), 128'd34);
        check_fill("post_rst_sram", 32'h0000_5000, 200);
        check_eq("post_rst_done", 128'(done_cnt), 128'd1);

        // Second req while busy is ignored
        do_clr(1'b0);
        run_move(1'b0, 32'h0, 32'h0000_6000, 0, 300, 0, 0, 0, 5, lat);
        check_eq("busy_req_latency", 128'(lat), 128'd34);
        repeat (10) @(negedge clk);
        check_eq("busy_req_done", {32'(done_cnt), 32'(rd_cnt), 31'd0, busy}, {32'd1, 32'd32, 32'd0});
        check_fill("busy_req_sram", 32'h0000_6000, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_line_mover.md
CACHE_LINE_MOVER -- requirements
Module: cache_line_mover

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning byte lanes per word; data width is 8*LANES.
REQ-002 SHALL have parameter BLOCK_WORDS, default 32, meaning words per cache block; power of two, at least 2.
REQ-003 SHALL have parameter SRAM_AW, default 10, meaning SRAM word-address width.
REQ-004 SHALL have ports, as follows:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  start a block move; sampled only in IDLE.
- evict  in  1  victim block is dirty; write it back before the fill.
- victim_addr  in  32  block-aligned byte address for the writeback.
- fill_addr  in  32  block-aligned byte address for the refill.
- fill_word  in  log2(BLOCK_WORDS)  critical word offset.
- sram_base  in  SRAM_AW  SRAM word index of the block start.
- busy  out  1  move in progress.
- done  out  1  one-cycle completion pulse.
- crit_valid  out  1  one-cycle pulse; crit_data is valid in that cycle.
- crit_data  out  8*LANES  forwarded critical word.
- mem_ren, mem_wen  out  1  main-memory read/write strobes.
- mem_addr  out  32  main-memory byte address.
- mem_din  out  8*LANES  write data to memory.
- mem_dout  in  8*LANES  read data, valid 1 cycle after an accepted mem_ren.
- mem_busy  in  1  memory stall; a strobe is accepted only when mem_busy=0.
- cell_din  out  8*LANES  SRAM write data, lane k is bits 8k+7:8k.
- cell_sense_en  out  LANES  per-lane SRAM read enable.
- cell_wen  out  LANES  per-lane SRAM write enable.
- cell_addr  out  SRAM_AW  shared SRAM address.
- cell_dout  in  8*LANES  SRAM read data, valid 1 cycle after sense_en.

Function
REQ-005 SHALL implement the FSM states IDLE, WB, FILL and DONE.
REQ-006 SHALL make these FSM transitions:
- IDLE->WB on req&evict.
- IDLE->FILL on req&!evict.
- WB->FILL after the last writeback is accepted.
- FILL->DONE after the last SRAM write.
- DONE->IDLE unconditionally.
REQ-007 SHALL register req, evict, victim_addr, fill_addr, fill_word and sram_base in the acceptance cycle; later changes to these inputs have no effect until IDLE.
REQ-008 SHALL ignore req while busy=1.
REQ-009 SHALL assert busy from the cycle after acceptance through the DONE cycle inclusive.
REQ-010 SHALL pulse done exactly once per move, in the DONE state.
REQ-011 SHALL perform writeback (WB) as follows:
- Order: words 0..BLOCK_WORDS-1, in linear order.
- SRAM reads: cell_sense_en all ones, with cell_addr = sram_base + i.
- Memory writes: mem_wen with mem_addr = victim_addr + LANES*i, and mem_din = cell_dout of word i.
- Pipelining: one word per cycle when unstalled.
REQ-012 SHALL, when mem_busy=1 during WB, hold mem_wen, mem_addr and mem_din stable and stop issuing SRAM reads. A one-entry holding register preserves the data; no word is lost or duplicated.
REQ-013 SHALL perform the refill (FILL) as follows:
- Memory reads: mem_ren with mem_addr = fill_addr + LANES*w.
- SRAM writes: the following cycle, cell_wen all ones, cell_addr = sram_base + w, cell_din = mem_dout.
- Pipelining: one word per cycle when unstalled.
REQ-014 SHALL, when mem_busy=1 during FILL, hold mem_ren and mem_addr and not advance the word counter. SRAM writes occur only for accepted reads.
REQ-015 SHALL pulse crit_valid with crit_data = mem_dout in the cycle word fill_word is written to SRAM.
REQ-016 SHALL use modulo-BLOCK_WORDS word-index arithmetic; SRAM addresses wrap modulo 2^SRAM_AW and memory addresses modulo 2^32.
REQ-017 SHALL never assert cell_wen and cell_sense_en in the same cycle, and never assert mem_ren and mem_wen together.
REQ-018 SHALL meet these latencies with mem_busy=0 and BLOCK_WORDS=32, counting the acceptance cycle as 0:
- Fill only: done at cycle 34.
- Evict plus fill: done at cycle 67.

Reset
REQ-019 SHALL, on rst=1, immediately force the following outputs to 0 and the FSM to IDLE: busy, done, crit_valid, crit_data, all mem_* strobes, addresses and data, and all cell_* outputs.
REQ-020 SHALL, on reset mid-move, abort without a done pulse; partially written SRAM and memory contents are left as-is.

Configuration
REQ-021 SHALL support macro CACHE_LINE_MOVER_CRITICAL_WORD_FIRST_EN:
- Defined: the refill order is w = (fill_word + j) mod BLOCK_WORDS for j = 0..BLOCK_WORDS-1, so crit_valid occurs on the first SRAM write.
- Undefined: the refill order is linear 0..BLOCK_WORDS-1, and crit_valid occurs when word fill_word arrives.
REQ-022 SHALL keep the writeback order, done timing and port list identical in both configurations.

Verification
REQ-023 SHALL cover a fill-only move: req, fill_addr=32'hACE12000, sram_base=0, fill_word=0 -> 32 SRAM writes at addresses 0..31 carrying memory words 32'hACE12000..32'hACE1207C, and done at cycle 34.
REQ-024 SHALL cover evict plus fill: evict=1, victim_addr=32'hBEEF2000, SRAM preloaded with word i = {4{8'(i)}} -> memory at 32'hBEEF2000+4i holds {4{8'(i)}}, then the refill, and done at cycle 67.
REQ-025 SHALL cover critical word first: macro defined, fill_word=31 -> the first mem_addr is fill_addr+124, crit_valid occurs in the first SRAM-write cycle, and the second read wraps to fill_addr+0. Macro undefined -> crit_valid occurs at the 32nd write.
REQ-026 SHALL cover a memory stall: mem_busy=1 for 5 cycles in mid-WB and again in mid-FILL -> memory and SRAM contents are still exact, done is delayed by exactly 10 cycles, and strobes hold stable during each stall.
REQ-027 SHALL cover reset mid-FILL: rst pulsed at cycle 10 -> all outputs are 0 asynchronously, no done pulse, and a new req is accepted normally.
REQ-028 SHALL cover req while busy: a second req at cycle 5 -> it is ignored, and exactly one done pulse occurs.
